cache_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache between the CPU-side 32-bit memory port and the line-wide physical-memory port. Successor to the fixed 2-way cache: configurable way count, set count and line size; tree pseudo-LRU replacement; invalid-way-first victim selection; hit/miss performance counters. It drops into the same slot as the 2-way cache.

---
 rtl/cache_nway_if.sv | 36 +++
 rtl/cache_nway.sv | 197 +++++++++++++++++++
 tb/tb_cache_nway.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_if.sv
// CPU-side word port and line-wide physical-memory port of cache_nway.
// slave: the cache's view. master: the CPU plus memory side that drives it.
interface cache_nway_if #(
    parameter int s_offset = 5
);
    localparam int s_line = 8 * (2 ** s_offset);

    logic [31:0]       mem_address;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_byte_enable;
    logic [31:0]       mem_rdata;
    logic              mem_resp;

    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic              pmem_resp;

    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_wdata, pmem_read, pmem_write
    );

    modport master (
        output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with tree PLRU.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | lookup; hits complete in the same cycle, misses pick victim
// WRITEBACK | dirty victim line is written to physical memory
// FILL      | requested line is read from physical memory into victim way
module cache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4
) (
    input  logic        clk,
    input  logic        rst,
    cache_nway_if.slave bus,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
);
    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int num_sets = 2 ** s_index;
    localparam int s_line   = 8 * (2 ** s_offset);
    localparam int s_way    = $clog2(num_ways);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
    state_t state_q, state_d;

    // PLRU vectors carry one spare top bit so node numbers index them directly.
    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [num_ways-1:0] plru_q  [num_sets];
    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [s_line-1:0]   data_q  [num_sets][num_ways];
    logic [s_way-1:0]    victim_q, victim_d;

    logic [s_tag-1:0]      req_tag;
    logic [s_index-1:0]    req_index;
    logic [s_offset-3:0]   req_word;
    logic                  req, is_write, hit, has_invalid, hit_access, fill_done;
    logic [s_way-1:0]      hit_way, inv_way, plru_way;
    logic [s_line-1:0]     wr_line;

    assign req_tag    = bus.mem_address[31 -: s_tag];
    assign req_index  = bus.mem_address[s_offset +: s_index];
    assign req_word   = bus.mem_address[2 +: s_offset-2];
    assign req        = bus.mem_read | bus.mem_write;
    assign is_write   = bus.mem_write;
    assign hit_access = (state_q == IDLE) && req && hit;
    assign fill_done  = (state_q == FILL) && bus.pmem_resp;

    // Marks every node on the path to way as pointing away from it.
    function automatic logic [num_ways-1:0] plru_touch(input logic [num_ways-1:0] bits,
                                                       input logic [s_way-1:0] way);
        logic [s_way-1:0] node;
        logic             b;
        plru_touch = bits;
        node = '0;
        for (int l = 0; l < s_way; l++) begin
            b = way[s_way-1-l];
            plru_touch[node] = ~b;
            node = s_way'({node, 1'b0} + {{s_way{1'b0}}, b} + 1'b1);
        end
    endfunction

    // Tag compare across the ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (valid_q[req_index][w] && tag_q[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = s_way'(w);
            end
        end
    end

    // Victim candidates: lowest invalid way, and the way the PLRU tree points at.
    always_comb begin
        logic [s_way-1:0] node;
        logic             b;
        has_invalid = 1'b0;
        inv_way     = '0;
        plru_way    = '0;
        node        = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[req_index][w]) begin
                has_invalid = 1'b1;
                inv_way     = s_way'(w);
            end
        end
        for (int l = 0; l < s_way; l++) begin
            b = plru_q[req_index][node];
            plru_way[s_way-1-l] = b;
            node = s_way'({node, 1'b0} + {{s_way{1'b0}}, b} + 1'b1);
        end
    end

    // Hit line with the enabled bytes of the addressed word replaced.
    always_comb begin
        wr_line = data_q[req_index][hit_way];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byte_enable[b]) begin
                wr_line[{req_word, 5'b0} + b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
            end
        end
    end

    // State and victim register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next state and all bus outputs.
    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        bus.mem_resp  = 1'b1;
                        bus.mem_rdata = data_q[req_index][hit_way][{req_word, 5'b0} +: 32];
                    end else begin
                        victim_d = has_invalid ? inv_way : plru_way;
                        state_d  = (valid_q[req_index][victim_d] && dirty_q[req_index][victim_d])
                                   ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[req_index][victim_q], req_index, {s_offset{1'b0}}};
                bus.pmem_wdata   = data_q[req_index][victim_q];
                if (bus.pmem_resp) state_d = FILL;
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, req_index, {s_offset{1'b0}}};
                if (bus.pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid, dirty and PLRU bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (hit_access) begin
                plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
                if (is_write) dirty_q[req_index][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[req_index][victim_q] <= 1'b1;
                dirty_q[req_index][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and line storage; reset only suppresses updates, contents persist.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_access && is_write) data_q[req_index][hit_way] <= wr_line;
            if (fill_done) begin
                data_q[req_index][victim_q] <= bus.pmem_rdata;
                tag_q[req_index][victim_q]  <= req_tag;
            end
        end
    end

    // Hit and miss counters; a miss is counted once, when it leaves IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit) perf_hits   <= perf_hits + 32'd1;
            else     perf_misses <= perf_misses + 32'd1;
        end
    end
endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: table of CPU accesses with expected
// latency, a reference word memory feeding a read-data scoreboard, a
// physical-memory responder, and hand-written reset/writeback sequences.
module tb_cache_nway;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_hits, perf_misses;

    cache_nway_if #(.s_offset(5)) bus ();

    cache_nway dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [21];
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [255:0] pmem_mem [logic [31:0]];

    int checks = 0;
    int failures = 0;
    int fill_count = 0;
    int wb_count = 0;
    logic [31:0]  last_fill_addr = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_line = '0;
    logic hold_resp = 1'b0;
    logic last_was_wb = 1'b0;
    int   resp_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return 32'h5A00_0000 ^ wa;
    endfunction

    function automatic logic [255:0] line_get(input logic [31:0] a);
        logic [255:0] l;
        if (pmem_mem.exists(a)) return pmem_mem[a];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h5A00_0000 ^ (a + 32'(i*4));
        return l;
    endfunction

    // Physical memory: answers each request after a fixed wait with a one-cycle pmem_resp.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                resp_wait = 0;
                if (last_was_wb) check("wb_to_fill_no_gap", {31'd0, bus.pmem_read}, 32'd1);
                last_was_wb = 1'b0;
            end else if ((bus.pmem_read || bus.pmem_write) && !hold_resp && !rst) begin
                check("pmem_rd_wr_exclusive", {31'd0, bus.pmem_read & bus.pmem_write}, 32'd0);
                if (resp_wait == 2) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        wb_count++;
                        last_wb_addr = bus.pmem_address;
                        last_wb_line = bus.pmem_wdata;
                        pmem_mem[bus.pmem_address] = bus.pmem_wdata;
                        last_was_wb = 1'b1;
                    end else begin
                        fill_count++;
                        last_fill_addr = bus.pmem_address;
                        bus.pmem_rdata = line_get(bus.pmem_address);
                    end
                end else begin
                    resp_wait++;
                end
            end else begin
                resp_wait = 0;
            end
        end
    end

    // One CPU access, entered and left at posedge+1. Returns cycles without mem_resp.
    task automatic cpu_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic rd, input logic wr, input string tag, output int lat);
        logic [31:0] e;
        logic [31:0] m;
        bus.mem_address     = a;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        if (rd && !wr) exp_q.push_back(ref_word(a));
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) break;
            lat++;
            if (lat > 100) break;
            @(posedge clk);
            #1;
        end
        if (lat > 100) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            if (rd && !wr) void'(exp_q.pop_front());
        end else begin
            if (rd && !wr) begin
                e = exp_q.pop_front();
                check({tag, "_rdata"}, bus.mem_rdata, e);
            end
            if (wr) begin
                m = ref_word(a);
                for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
                ref_mem[{a[31:2], 2'b00}] = m;
            end
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        int lat;
        int h0, m0;
        logic [255:0] pre;
        logic seen;

        vecs[0]  = '{32'h0000_0044, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[1]  = '{32'h0000_0044, 32'h1122_3344,  4'h3, 1'b0, 1'b1, 0};
        vecs[2]  = '{32'h0000_0044, 32'h0,          4'h0, 1'b1, 1'b0, 0};
        vecs[3]  = '{32'h0000_0000, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[4]  = '{32'h0000_0100, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[5]  = '{32'h0000_0200, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[6]  = '{32'h0000_0300, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[7]  = '{32'h0000_0004, 32'h0,          4'h0, 1'b1, 1'b0, 0};
        vecs[8]  = '{32'h0000_0400, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[9]  = '{32'h0000_0000, 32'h0,          4'h0, 1'b1, 1'b0, 0};
        vecs[10] = '{32'h0000_0100, 32'h0,          4'h0, 1'b1, 1'b0, 0};
        vecs[11] = '{32'h0000_0300, 32'h0,          4'h0, 1'b1, 1'b0, 0};
        vecs[12] = '{32'h0000_0200, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[13] = '{32'h0000_0028, 32'hCAFE_F00D,  4'hF, 1'b0, 1'b1, 4};
        vecs[14] = '{32'h0000_0120, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[15] = '{32'h0000_0220, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[16] = '{32'h0000_0320, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[17] = '{32'h0000_0420, 32'h0,          4'h0, 1'b1, 1'b0, 8};
        vecs[18] = '{32'h0000_0028, 32'h0,          4'h0, 1'b1, 1'b0, 4};
        vecs[19] = '{32'h0000_0124, 32'h0BAD_C0DE,  4'hF, 1'b1, 1'b1, 0};
        vecs[20] = '{32'h0000_0124, 32'h0,          4'h0, 1'b1, 1'b0, 0};

        pre = line_get(32'h40);
        pre[63:32] = 32'hDEAD_BEEF;
        pmem_mem[32'h40] = pre;
        ref_mem[32'h44]  = 32'hDEAD_BEEF;

        rst = 1'b1;
        bus.mem_address = '0;
        bus.mem_wdata = '0;
        bus.mem_byte_enable = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_mem_resp",     {31'd0, bus.mem_resp},   32'd0);
        check("reset_pmem_read",    {31'd0, bus.pmem_read},  32'd0);
        check("reset_pmem_write",   {31'd0, bus.pmem_write}, 32'd0);
        check("reset_pmem_address", bus.pmem_address,        32'd0);
        check("reset_perf_hits",    perf_hits,               32'd0);
        check("reset_perf_misses",  perf_misses,             32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            h0 = int'(perf_hits);
            m0 = int'(perf_misses);
            cpu_op(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rd, vecs[i].wr,
                   $sformatf("v%0d", i), lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_hits_delta", i), perf_hits - 32'(h0), 32'd1);
            check($sformatf("v%0d_misses_delta", i), perf_misses - 32'(m0),
                  (vecs[i].exp_lat == 0) ? 32'd0 : 32'd1);
            if (i == 0) begin
                check("fill_line_address", last_fill_addr, 32'h40);
                check("first_perf_hits",   perf_hits,      32'd1);
                check("first_perf_misses", perf_misses,    32'd1);
            end
            if (i == 2) begin
                check("hit_write_no_fill", 32'(fill_count), 32'd1);
                check("hit_write_no_wb",   32'(wb_count),   32'd0);
            end
            if (i == 17) begin
                check("wb_count",    32'(wb_count),         32'd1);
                check("wb_address",  last_wb_addr,          32'h20);
                check("wb_word2",    last_wb_line[95:64],   32'hCAFE_F00D);
                check("wb_word0",    last_wb_line[31:0],    32'h5A00_0020);
                check("fill_after_wb_address", last_fill_addr, 32'h420);
            end
        end

        // Reset while FILL waits for physical memory.
        hold_resp = 1'b1;
        bus.mem_address = 32'h0000_0A40;
        bus.mem_byte_enable = 4'h0;
        bus.mem_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus.pmem_read;
        end
        check("fill_started_before_rst", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drops_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
        check("rst_clears_misses",   perf_misses,             32'd0);
        rst = 1'b0;
        bus.mem_read = 1'b0;
        hold_resp = 1'b0;
        @(posedge clk);
        #1;
        cpu_op(32'h0000_0A40, 32'h0, 4'h0, 1'b1, 1'b0, "after_rst", lat);
        check("after_rst_misses_again", 32'(lat),    32'd4);
        check("after_rst_perf_misses",  perf_misses, 32'd1);
        check("after_rst_perf_hits",    perf_hits,   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
